// File: rtl/icap_cfg_streamer.sv
// icap_cfg_streamer: drives an ICAP_VIRTEX6 port in X32 mode from a simple
// command + 32-bit word stream. CSB is always high whenever RDWRB changes,
// and data is bit-reversed within each byte in both directions when BIT_SWAP=1.
// Optional read watchdog: define ICAP_CFG_STREAMER_TIMEOUT_EN.
module icap_cfg_streamer #(
  parameter int unsigned LEN_W       = 16,
  parameter bit          BIT_SWAP    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_READ,
  input  logic [LEN_W-1:0] CMD_LEN,
  input  logic [31:0]      WR_DATA,
  input  logic             WR_VALID,
  output logic             WR_READY,
  output logic [31:0]      RD_DATA,
  output logic             RD_VALID,
  output logic             DONE,
  output logic             ERR,
  output logic             ICAP_CSB,
  output logic             ICAP_RDWRB,
  output logic [31:0]      ICAP_I,
  input  logic             ICAP_BUSY,
  input  logic [31:0]      ICAP_O
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_WR_END  = 3'd2,
    S_RD_TURN = 3'd3,
    S_READ    = 3'd4,
    S_RD_EXIT = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  // Reverse bit order inside each byte; byte order is left alone.
  function automatic logic [31:0] swap_bits(input logic [31:0] din);
    logic [31:0] dout;
    dout = din;
    if (BIT_SWAP) begin
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 8; i++) begin
          dout[8*b+i] = din[8*b+7-i];
        end
      end
    end else begin
      dout = din;
    end
    return dout;
  endfunction

  state_t           state_r;
  logic [LEN_W-1:0] remaining_r;
  logic             icap_csb_r;
  logic             icap_rdwrb_r;
  logic [31:0]      icap_i_r;
  logic [31:0]      rd_data_r;
  logic             rd_valid_r;
  logic             done_r;
  logic             wr_ready_s;
  logic             rd_capture_s;

`ifdef ICAP_CFG_STREAMER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  logic [TO_W-1:0] to_cnt_r;
  logic            err_r;
  assign ERR = err_r;
`else
  assign ERR = 1'b0;
`endif

  // Handshake readiness is a pure state decode, forced low during reset.
  assign CMD_READY  = RSTB && (state_r == S_IDLE);
  assign wr_ready_s = RSTB && (state_r == S_WRITE) && (remaining_r != LEN_ZERO);
  assign WR_READY   = wr_ready_s;

  // A readback word is valid only once the registered pins are in read mode.
  assign rd_capture_s = !icap_csb_r && icap_rdwrb_r && !ICAP_BUSY;

  assign ICAP_CSB   = icap_csb_r;
  assign ICAP_RDWRB = icap_rdwrb_r;
  assign ICAP_I     = icap_i_r;
  assign RD_DATA    = rd_data_r;
  assign RD_VALID   = rd_valid_r;
  assign DONE       = done_r;

  // Command sequencer: owns every ICAP pin and all fabric-side strobes.
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_r      <= S_IDLE;
      remaining_r  <= LEN_ZERO;
      icap_csb_r   <= 1'b1;
      icap_rdwrb_r <= 1'b0;
      icap_i_r     <= 32'h0000_0000;
      rd_data_r    <= 32'h0000_0000;
      rd_valid_r   <= 1'b0;
      done_r       <= 1'b0;
`ifdef ICAP_CFG_STREAMER_TIMEOUT_EN
      to_cnt_r     <= {TO_W{1'b0}};
      err_r        <= 1'b0;
`endif
    end else begin
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (CMD_VALID) begin
            remaining_r <= CMD_LEN;
`ifdef ICAP_CFG_STREAMER_TIMEOUT_EN
            err_r       <= 1'b0;
`endif
            if (CMD_LEN == LEN_ZERO) begin
              done_r  <= 1'b1;
            end else if (CMD_READ) begin
              state_r <= S_RD_TURN;
            end else begin
              state_r <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (WR_VALID && wr_ready_s) begin
            icap_i_r    <= swap_bits(WR_DATA);
            icap_csb_r  <= 1'b0;
            remaining_r <= remaining_r - LEN_ONE;
            if (remaining_r == LEN_ONE) begin
              state_r <= S_WR_END;
            end
          end else begin
            // Gap in the stream: deselect, keep the last word on the bus.
            icap_csb_r <= 1'b1;
          end
        end
        S_WR_END: begin
          icap_csb_r <= 1'b1;
          done_r     <= 1'b1;
          state_r    <= S_IDLE;
        end
        S_RD_TURN: begin
          // CSB is still high here, so RDWRB may switch safely.
          icap_rdwrb_r <= 1'b1;
`ifdef ICAP_CFG_STREAMER_TIMEOUT_EN
          to_cnt_r     <= {TO_W{1'b0}};
`endif
          state_r      <= S_READ;
        end
        S_READ: begin
          icap_csb_r <= 1'b0;
          if (rd_capture_s) begin
            rd_data_r   <= swap_bits(ICAP_O);
            rd_valid_r  <= 1'b1;
            remaining_r <= remaining_r - LEN_ONE;
`ifdef ICAP_CFG_STREAMER_TIMEOUT_EN
            to_cnt_r    <= {TO_W{1'b0}};
`endif
            if (remaining_r == LEN_ONE) begin
              icap_csb_r <= 1'b1;
              state_r    <= S_RD_EXIT;
            end
          end
`ifdef ICAP_CFG_STREAMER_TIMEOUT_EN
          else if (ICAP_BUSY) begin
            if (to_cnt_r == TO_LAST) begin
              err_r      <= 1'b1;
              icap_csb_r <= 1'b1;
              state_r    <= S_RD_EXIT;
            end else begin
              to_cnt_r <= to_cnt_r + TO_ONE;
            end
          end
`endif
        end
        S_RD_EXIT: begin
          icap_rdwrb_r <= 1'b0;
          done_r       <= 1'b1;
          state_r      <= S_IDLE;
        end
        default: begin
          icap_csb_r   <= 1'b1;
          icap_rdwrb_r <= 1'b0;
          state_r      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/icap_cfg_streamer.md
Name: icap_cfg_streamer

Overview:
- Upstream driver for the ICAP_VIRTEX6 configuration port in X32 mode.
- Accepts write/readback commands plus a 32-bit word stream from fabric logic.
- Sequences ICAP_CSB/ICAP_RDWRB with the required CSB-high turnaround around every RDWRB change.
- Performs per-byte bit reversal on data in both directions and returns readback words to the fabric.

Parameters:
- LEN_W, 16, width of the command word count.
- BIT_SWAP, 1, 1 = reverse bits within each byte on ICAP_I and ICAP_O; 0 = pass data straight through.
- TIMEOUT_CYC, 4096, watchdog limit in cycles, used only with the optional feature.

Ports:
- CLK  in  1  clock, shared with the ICAP_VIRTEX6 CLK pin.
- RSTB  in  1  synchronous, active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE.
- CMD_READ  in  1  0 = write, 1 = readback.
- CMD_LEN  in  LEN_W  number of words to transfer.
- WR_DATA  in  32  write word.
- WR_VALID  in  1  write word valid.
- WR_READY  out  1  write word accepted.
- RD_DATA  out  32  readback word, bit-swapped per BIT_SWAP.
- RD_VALID  out  1  one-cycle strobe per readback word; no backpressure.
- DONE  out  1  one-cycle pulse when a command completes.
- ERR  out  1  sticky watchdog error, cleared by the next accepted command.
- ICAP_CSB  out  1  to ICAP CSB.
- ICAP_RDWRB  out  1  to ICAP RDWRB.
- ICAP_I  out  32  to ICAP I.
- ICAP_BUSY  in  1  from ICAP BUSY.
- ICAP_O  in  32  from ICAP O.

Behaviour:
- Reset (RSTB low at a CLK edge), all values:
  - ICAP_CSB=1, ICAP_RDWRB=0, ICAP_I=0.
  - RD_DATA=0, RD_VALID=0, DONE=0, ERR=0.
  - state=IDLE, remaining count=0.
  - CMD_READY and WR_READY low while RSTB is low.
- Reset mid-command aborts the command immediately. No DONE is issued. ICAP_CSB returns high on the same edge.
- All ICAP_* outputs, RD_DATA, RD_VALID and DONE are registered. CMD_READY and WR_READY are decoded from state.
- States: IDLE, WRITE, WR_END, RD_TURN, READ, RD_EXIT.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID, latch CMD_LEN into remaining and clear ERR.
  - CMD_LEN=0 → stay IDLE and pulse DONE on the next cycle; ICAP pins untouched.
  - CMD_READ=0 → WRITE.
  - CMD_READ=1 → RD_TURN.
- WRITE:
  - WR_READY=1 while remaining>0.
  - On WR_VALID&&WR_READY: ICAP_I<=swap(WR_DATA), ICAP_CSB<=0, remaining decrements.
  - A cycle with no handshake sets ICAP_CSB<=1 (a gap); ICAP_I holds its value.
  - After the last handshake → WR_END.
  - ICAP_BUSY is ignored during writes.
- WR_END: ICAP_CSB<=1, DONE<=1, then → IDLE. Write latency is one cycle from handshake to ICAP pins.
- RD_TURN: ICAP_CSB stays 1; ICAP_RDWRB<=1; → READ next cycle.
  - RDWRB therefore changes only while CSB=1.
- READ:
  - ICAP_CSB<=0.
  - Each cycle with registered ICAP_CSB==0, ICAP_RDWRB==1 and ICAP_BUSY==0: RD_DATA<=swap(ICAP_O), RD_VALID<=1, remaining decrements.
  - Otherwise RD_VALID<=0.
  - On the capture of the final word: ICAP_CSB<=1 on the same edge, then → RD_EXIT.
- RD_EXIT: ICAP_RDWRB<=0 (CSB already 1), DONE<=1, then → IDLE.
- Command acceptance: CMD_VALID is ignored outside IDLE. A new command can be accepted on the cycle after DONE.
- swap(): bit 7-i ↔ bit i within each byte when BIT_SWAP=1. Byte order is never changed.
- remaining: unsigned LEN_W bits, counts down to 0 and never wraps. A maximum CMD_LEN of 2^LEN_W-1 is legal.

Optional Feature:
- Macro: ICAP_CFG_STREAMER_TIMEOUT_EN.
- Enabled:
  - A counter runs in READ while ICAP_BUSY=1, reset on each captured word.
  - On reaching TIMEOUT_CYC: ERR<=1, ICAP_CSB<=1, → RD_EXIT, which issues DONE normally.
  - A short word count is implied.
- Disabled:
  - No counter is instantiated and ERR is tied to 0.
  - READ waits indefinitely on ICAP_BUSY.

Test Plan:
- Write 3 words (32'h0000_0001, 32'hAA99_5566, 32'h3000_8001), BIT_SWAP=1, WR_VALID continuous:
  - ICAP_I shows 32'h0000_0080, 32'h5599_AA66, 32'h0C00_0180 on three consecutive cycles with ICAP_CSB=0, ICAP_RDWRB=0.
  - Then CSB=1 and a single DONE pulse.
- Write 2 words with WR_VALID low for 2 cycles between them → ICAP_CSB high exactly during the gap, 2 ICAP writes total, DONE once.
- Read CMD_LEN=2, ICAP_BUSY pattern 1,1,0,1,0, ICAP_O=32'h0000_0080 then 32'hFFFF_FFFF:
  - RDWRB rises one cycle before CSB falls.
  - RD_VALID pulses twice with RD_DATA 32'h0000_0001 and 32'hFFFF_FFFF.
  - CSB rises before RDWRB falls.
  - DONE pulses once.
- CMD_LEN=0, CMD_READ=1 → DONE one cycle later; ICAP_CSB=1 and ICAP_RDWRB=0 throughout.
- RSTB low for one cycle during READ after 1 of 4 words → next cycle ICAP_CSB=1, ICAP_RDWRB=0, RD_VALID=0, CMD_READY=1 once RSTB is high; no DONE.
- With ICAP_CFG_STREAMER_TIMEOUT_EN and TIMEOUT_CYC=16, read with ICAP_BUSY held 1 → after 16 cycles ERR=1, CSB=1, then RDWRB=0 and DONE; the next command clears ERR.
